packet_framer: RTL and testbench
================================

// Module: packet_framer
// PURPOSE
//  Sits directly downstream of the per-byte symbol classifier. Consumes each classified byte
//  (one-hot type + TLP/DLLP kind) and rebuilds framed packets: strips STP/SDP/END/EDB
//  symbols, marks first/last payload bytes, counts length, flags framing errors, and
//  buffers the result in a FIFO drained by a valid/ready consumer.
// PARAMETERS
//  FIFO_DEPTH   16    output FIFO entries (power of 2, >=4)
//  LEN_W        12    width of payload length counter/output
//  MAX_TLP_LEN  4095  max TLP payload bytes; more -> err on that packet
//  DLLP_LEN     6     required DLLP payload byte count
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  byte_in      in   8      byte from classifier, same cycle as type_in
//  type_in      in   6      one-hot: 100000 data, 010000 tlpstart, 001000 tlpend,
//                           000100 dllpend, 000010 dllpstart, 000001 tlpedb, 000000 none
//  kind_in      in   2      01 TLP, 10 DLLP, 00 none (classifier's kind output)
//  out_ready    in   1      consumer accepts out_* when out_valid & out_ready
//  out_valid    out  1      FIFO head valid
//  out_data     out  8      payload byte
//  out_sop/eop  out  1 each first/last byte of packet
//  out_kind     out  2      01 TLP, 10 DLLP
//  out_err      out  1      on eop entry only: packet bad (EDB, length, overflow, abort)
//  pkt_len      out  LEN_W  payload byte count, valid with out_eop
//  frame_err    out  1      1-cycle pulse: stray end/data-less packet/start-in-packet
//  overflow     out  1      sticky, set when a byte is lost to full FIFO; cleared by reset
// BEHAVIOUR
//  Reset: FSM=IDLE, hold reg empty, count=0, FIFO empty; all outputs 0.
//  FSM states IDLE, IN_TLP, IN_DLLP, DROP. type_in=000000 ignored in every state.
//  IDLE: tlpstart->IN_TLP, dllpstart->IN_DLLP (count=0, sop_pending=1); any end/edb -> frame_err;
//   data ignored.
//  IN_TLP/IN_DLLP, data: if hold full push hold to FIFO; load byte into hold; count++.
//   First loaded byte carries sop. Hold register gives the one-byte lookahead for eop.
//  tlpend in IN_TLP / dllpend in IN_DLLP: push hold with eop=1, pkt_len=count;
//   err=1 if DLLP count!=DLLP_LEN or TLP count>MAX_TLP_LEN (count saturates). -> IDLE.
//  tlpedb (either packet state): push hold with eop=1, err=1 (nullified). -> IDLE.
//  End with hold empty (no payload): nothing pushed, frame_err pulse, -> IDLE.
//  Mismatched end (dllpend in IN_TLP or vice versa): treated as abort: eop, err=1, frame_err.
//  tlpstart/dllpstart inside packet: close current (eop, err=1), frame_err, open new same cycle.
//  Overflow: push needed while FIFO full -> byte lost, overflow=1, FSM->DROP, term_pending=1.
//   DROP ignores data until end/edb/start; start opens new packet only once terminator pushed.
//   term_pending: push entry {data=0,eop=1,err=1} as soon as FIFO not full; until then all
//   input bytes dropped. Guarantees every sop is matched by exactly one eop.
//  Simultaneous push and pop on full FIFO: pop frees space, push succeeds (no overflow).
//  Latency: data byte at cycle N visible at FIFO head no earlier than N+2 after next symbol.
//  FIFO entry = {data, sop, eop, err, kind, len}; pointers wrap mod FIFO_DEPTH, extra
//   MSB distinguishes full/empty. out_* are FIFO head, stable while out_valid & !out_ready.
// STRUCTURE
//  pkt_id_pkg: type one-hot constants, kind constants (TLP/DLLP/NONE), FSM state enum.
//  Sub-module framer_fifo: sync FIFO, parameters WIDTH/DEPTH, push/pop/full/empty.
//  Top holds FSM, hold register, length counter, terminator logic.
// TESTING
//  STP,data 11,22,33,END -> 3 entries: 11 sop, 22, 33 eop; kind=01, len=3, err=0.
//  SDP, 6 data bytes, END -> 6 entries kind=10, len=6, err=0; with 5 bytes -> err=1.
//  STP,AA,BB,EDB -> BB eop err=1; then SDP..END normal packet unaffected.
//  out_ready=0, 20-byte TLP, FIFO_DEPTH=16 -> overflow=1, terminator eop err=1 after drain.
//  END in IDLE, and STP,END -> frame_err pulse each, no FIFO entries.
//  STP,01,02,STP,03,END -> 01 sop,02 eop err=1 frame_err; 03 sop+eop len=1 err=0.

Source files
------------

// File: rtl/pkt_id_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_id_pkg
//  Description : Shared symbol-type, packet-kind and framer state encodings
//                used by the packet framer and its output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkt_id_pkg;

    // One-hot symbol types produced by the upstream classifier
    localparam logic [5:0] c_TYPE_NONE       = 6'b000000;
    localparam logic [5:0] c_TYPE_DATA       = 6'b100000;
    localparam logic [5:0] c_TYPE_TLP_START  = 6'b010000;
    localparam logic [5:0] c_TYPE_TLP_END    = 6'b001000;
    localparam logic [5:0] c_TYPE_DLLP_END   = 6'b000100;
    localparam logic [5:0] c_TYPE_DLLP_START = 6'b000010;
    localparam logic [5:0] c_TYPE_TLP_EDB    = 6'b000001;

    // Packet kind codes
    localparam logic [1:0] c_KIND_NONE = 2'b00;
    localparam logic [1:0] c_KIND_TLP  = 2'b01;
    localparam logic [1:0] c_KIND_DLLP = 2'b10;

    // Framer FSM states
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_IN_TLP  = 2'd1;
    localparam state_t c_ST_IN_DLLP = 2'd2;
    localparam state_t c_ST_DROP    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/framer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : framer_fifo
//  Description : Synchronous FIFO with extra-MSB pointers. A push into a full
//                FIFO is accepted when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module framer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage array; no reset needed since the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
        end
    end

    // Read/write pointers wrap naturally; the extra MSB separates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/packet_framer.sv
`default_nettype none
// ============================================================================
//  Module      : packet_framer
//  Description : Rebuilds framed TLP/DLLP packets from classified bytes,
//                marks sop/eop, counts length, flags framing errors and
//                buffers the payload in an output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_framer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int LEN_W       = 12,
    parameter int MAX_TLP_LEN = 4095,
    parameter int DLLP_LEN    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic [5:0]       type_in,
    input  logic [1:0]       kind_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic [1:0]       out_kind,
    output logic             out_err,
    output logic [LEN_W-1:0] pkt_len,
    output logic             frame_err,
    output logic             overflow
);

    import pkt_id_pkg::*;

    localparam int               c_ENTRY_W  = 13 + LEN_W;
    localparam logic [LEN_W-1:0] c_MAX_LEN  = LEN_W'(MAX_TLP_LEN);
    localparam logic [LEN_W-1:0] c_DLLP_LEN = LEN_W'(DLLP_LEN);

    // Registered framer state
    state_t           r_state;
    logic             r_hold_valid;
    logic [7:0]       r_hold_data;
    logic             r_hold_sop;
    logic             r_sop_pending;
    logic [LEN_W-1:0] r_count;
    logic             r_len_ovf;
    logic [1:0]       r_kind;
    logic             r_term_pending;
    logic             r_term_sop;
    logic             r_overflow;
    logic             r_frame_err;

    // Next-state values
    state_t           w_state_nxt;
    logic             w_hold_valid_nxt;
    logic [7:0]       w_hold_data_nxt;
    logic             w_hold_sop_nxt;
    logic             w_sop_pending_nxt;
    logic [LEN_W-1:0] w_count_nxt;
    logic             w_len_ovf_nxt;
    logic [1:0]       w_kind_nxt;
    logic             w_term_pending_nxt;
    logic             w_term_sop_nxt;
    logic             w_overflow_nxt;
    logic             w_frame_err;

    // FIFO write side
    logic                 w_push;
    logic [7:0]           w_push_data;
    logic                 w_push_sop;
    logic                 w_push_eop;
    logic                 w_push_err;
    logic [LEN_W-1:0]     w_push_len;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic                 w_can_push;

    // Symbol decode and per-cycle actions
    logic w_is_data;
    logic w_is_tlp_start;
    logic w_is_dllp_start;
    logic w_is_start;
    logic w_is_term;
    logic w_match_end;
    logic w_mism_end;
    logic w_len_err;
    logic w_do_open;
    logic w_do_load;
    logic w_do_lose;

    // The classifier's kind is implied by the one-hot type; kept on the port for pin compatibility
    logic w_unused_kind;
    assign w_unused_kind = ^kind_in;

    assign w_is_data       = (type_in == c_TYPE_DATA);
    assign w_is_tlp_start  = (type_in == c_TYPE_TLP_START);
    assign w_is_dllp_start = (type_in == c_TYPE_DLLP_START);
    assign w_is_start      = w_is_tlp_start || w_is_dllp_start;
    assign w_is_term       = (type_in == c_TYPE_TLP_END) || (type_in == c_TYPE_DLLP_END) ||
                             (type_in == c_TYPE_TLP_EDB);
    assign w_match_end     = ((r_state == c_ST_IN_TLP)  && (type_in == c_TYPE_TLP_END)) ||
                             ((r_state == c_ST_IN_DLLP) && (type_in == c_TYPE_DLLP_END));
    assign w_mism_end      = ((r_state == c_ST_IN_TLP)  && (type_in == c_TYPE_DLLP_END)) ||
                             ((r_state == c_ST_IN_DLLP) && (type_in == c_TYPE_TLP_END));
    // Count saturates at the TLP maximum; r_len_ovf records bytes beyond it
    assign w_len_err       = (r_state == c_ST_IN_DLLP) ? (r_count != c_DLLP_LEN) : r_len_ovf;

    assign w_pop      = !w_fifo_empty && out_ready;
    assign w_can_push = !w_fifo_full || w_pop;

    // Next-state and FIFO push decision
    always_comb begin
        w_state_nxt        = r_state;
        w_hold_valid_nxt   = r_hold_valid;
        w_hold_data_nxt    = r_hold_data;
        w_hold_sop_nxt     = r_hold_sop;
        w_sop_pending_nxt  = r_sop_pending;
        w_count_nxt        = r_count;
        w_len_ovf_nxt      = r_len_ovf;
        w_kind_nxt         = r_kind;
        w_term_pending_nxt = r_term_pending;
        w_term_sop_nxt     = r_term_sop;
        w_overflow_nxt     = r_overflow;
        w_frame_err        = 1'b0;
        w_push             = 1'b0;
        w_push_data        = r_hold_data;
        w_push_sop         = r_hold_sop;
        w_push_eop         = 1'b0;
        w_push_err         = 1'b0;
        w_push_len         = '0;
        w_do_open          = 1'b0;
        w_do_load          = 1'b0;
        w_do_lose          = 1'b0;

        if (r_term_pending) begin
            // All input is dropped until the closing terminator lands in the FIFO
            if (w_can_push) begin
                w_push             = 1'b1;
                w_push_data        = 8'h00;
                w_push_sop         = r_term_sop;
                w_push_eop         = 1'b1;
                w_push_err         = 1'b1;
                w_push_len         = r_count;
                w_term_pending_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_is_start)     w_do_open   = 1'b1;
                    else if (w_is_term) w_frame_err = 1'b1;
                end
                c_ST_DROP: begin
                    if (w_is_start)     w_do_open   = 1'b1;
                    else if (w_is_term) w_state_nxt = c_ST_IDLE;
                end
                default: begin
                    if (w_is_data) begin
                        if (r_hold_valid) w_push = 1'b1;
                        if (!r_hold_valid || w_can_push) w_do_load = 1'b1;
                        else                             w_do_lose = 1'b1;
                    end else if (w_is_term || w_is_start) begin
                        if (w_mism_end || w_is_start) w_frame_err = 1'b1;
                        if (!r_hold_valid) begin
                            // Packet closed with no payload: nothing to push
                            w_frame_err = 1'b1;
                            w_state_nxt = c_ST_IDLE;
                            w_do_open   = w_is_start;
                        end else begin
                            w_push     = 1'b1;
                            w_push_eop = 1'b1;
                            w_push_err = w_match_end ? w_len_err : 1'b1;
                            w_push_len = r_count;
                            if (w_can_push) begin
                                w_hold_valid_nxt = 1'b0;
                                w_state_nxt      = c_ST_IDLE;
                                w_do_open        = w_is_start;
                            end else begin
                                w_do_lose = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end

        if (w_do_open) begin
            w_state_nxt       = w_is_tlp_start ? c_ST_IN_TLP : c_ST_IN_DLLP;
            w_kind_nxt        = w_is_tlp_start ? c_KIND_TLP : c_KIND_DLLP;
            w_count_nxt       = '0;
            w_len_ovf_nxt     = 1'b0;
            w_sop_pending_nxt = 1'b1;
            w_hold_valid_nxt  = 1'b0;
        end

        if (w_do_load) begin
            w_hold_valid_nxt  = 1'b1;
            w_hold_data_nxt   = byte_in;
            w_hold_sop_nxt    = r_sop_pending;
            w_sop_pending_nxt = 1'b0;
            if (r_count == c_MAX_LEN) w_len_ovf_nxt = 1'b1;
            else                      w_count_nxt   = r_count + 1'b1;
        end

        if (w_do_lose) begin
            // If the lost byte carried sop, the terminator must open and close the packet
            w_push             = 1'b0;
            w_overflow_nxt     = 1'b1;
            w_state_nxt        = c_ST_DROP;
            w_term_pending_nxt = 1'b1;
            w_term_sop_nxt     = r_hold_sop;
            w_hold_valid_nxt   = 1'b0;
        end
    end

    // State, hold register, counters and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_ST_IDLE;
            r_hold_valid   <= 1'b0;
            r_hold_data    <= 8'h00;
            r_hold_sop     <= 1'b0;
            r_sop_pending  <= 1'b0;
            r_count        <= '0;
            r_len_ovf      <= 1'b0;
            r_kind         <= c_KIND_NONE;
            r_term_pending <= 1'b0;
            r_term_sop     <= 1'b0;
            r_overflow     <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hold_valid   <= w_hold_valid_nxt;
            r_hold_data    <= w_hold_data_nxt;
            r_hold_sop     <= w_hold_sop_nxt;
            r_sop_pending  <= w_sop_pending_nxt;
            r_count        <= w_count_nxt;
            r_len_ovf      <= w_len_ovf_nxt;
            r_kind         <= w_kind_nxt;
            r_term_pending <= w_term_pending_nxt;
            r_term_sop     <= w_term_sop_nxt;
            r_overflow     <= w_overflow_nxt;
            r_frame_err    <= w_frame_err;
        end
    end

    assign w_push_entry = {w_push_data, w_push_sop, w_push_eop, w_push_err, r_kind, w_push_len};

    framer_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign out_valid = !w_fifo_empty;
    assign {out_data, out_sop, out_eop, out_err, out_kind, pkt_len} = w_head;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_packet_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_framer
//  Description : Directed self-checking bench for packet_framer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_framer;

    import pkt_id_pkg::*;

    typedef struct packed {
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [1:0]  kind;
        logic [11:0] len;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic [5:0]  type_in = 6'b0;
    logic [1:0]  kind_in = 2'b00;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_kind;
    logic        out_err;
    logic [11:0] pkt_len;
    logic        frame_err;
    logic        overflow;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     fe_cnt   = 0;
    int     fe0;
    entry_t r_q[$];

    packet_framer #(
        .FIFO_DEPTH  (16),
        .LEN_W       (12),
        .MAX_TLP_LEN (4095),
        .DLLP_LEN    (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_in   (byte_in),
        .type_in   (type_in),
        .kind_in   (kind_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_kind  (out_kind),
        .out_err   (out_err),
        .pkt_len   (pkt_len),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Capture every accepted FIFO entry and count frame_err pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready)
                r_q.push_back('{out_data, out_sop, out_eop, out_err, out_kind, pkt_len});
            if (frame_err) fe_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [5:0] t, input logic [7:0] b);
        @(posedge clk);
        #1;
        type_in = t;
        byte_in = b;
        if (t == c_TYPE_TLP_START || t == c_TYPE_TLP_END || t == c_TYPE_TLP_EDB)
            kind_in = c_KIND_TLP;
        else if (t == c_TYPE_DLLP_START || t == c_TYPE_DLLP_END)
            kind_in = c_KIND_DLLP;
        else
            kind_in = c_KIND_NONE;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            type_in = c_TYPE_NONE;
            byte_in = 8'h00;
            kind_in = c_KIND_NONE;
        end
    endtask

    task automatic expect_entry(input string tag, input logic [7:0] d, input logic s,
                                input logic e, input logic er, input logic [1:0] k,
                                input logic [11:0] l, input bit chk_len);
        entry_t x;
        if (r_q.size() == 0) begin
            check_eq({tag, " present"}, 32'd0, 32'd1);
            return;
        end
        x = r_q.pop_front();
        check_eq({tag, " data"}, x.data, d);
        check_eq({tag, " sop"},  x.sop,  s);
        check_eq({tag, " eop"},  x.eop,  e);
        check_eq({tag, " err"},  x.err,  er);
        check_eq({tag, " kind"}, x.kind, k);
        if (chk_len) check_eq({tag, " len"}, x.len, l);
    endtask

    task automatic expect_none(input string tag);
        check_eq(tag, r_q.size(), 0);
        r_q.delete();
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst out_data",  out_data,  0);
        check_eq("rst out_eop",   out_eop,   0);
        check_eq("rst frame_err", frame_err, 0);
        check_eq("rst overflow",  overflow,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // T1: basic TLP
        fe0 = fe_cnt;
        send(c_TYPE_TLP_START, 8'h00);
        send(c_TYPE_DATA, 8'h11);
        send(c_TYPE_DATA, 8'h22);
        send(c_TYPE_DATA, 8'h33);
        send(c_TYPE_TLP_END, 8'h00);
        idle(6);
        expect_entry("t1 b0", 8'h11, 1, 0, 0, 2'b01, 0, 0);
        expect_entry("t1 b1", 8'h22, 0, 0, 0, 2'b01, 0, 0);
        expect_entry("t1 b2", 8'h33, 0, 1, 0, 2'b01, 3, 1);
        expect_none("t1 extra");
        check_eq("t1 fe", fe_cnt - fe0, 0);
        check_eq("t1 drained", out_valid, 0);

        // T2: DLLP with the required 6 bytes
        send(c_TYPE_DLLP_START, 8'h00);
        for (int i = 0; i < 6; i++) send(c_TYPE_DATA, 8'hA0 + 8'(i));
        send(c_TYPE_DLLP_END, 8'h00);
        idle(6);
        for (int i = 0; i < 6; i++)
            expect_entry($sformatf("t2 b%0d", i), 8'hA0 + 8'(i), (i == 0), (i == 5), 0,
                         2'b10, 6, (i == 5));
        expect_none("t2 extra");

        // T3: DLLP one byte short
        send(c_TYPE_DLLP_START, 8'h00);
        for (int i = 0; i < 5; i++) send(c_TYPE_DATA, 8'hB0 + 8'(i));
        send(c_TYPE_DLLP_END, 8'h00);
        idle(6);
        for (int i = 0; i < 5; i++)
            expect_entry($sformatf("t3 b%0d", i), 8'hB0 + 8'(i), (i == 0), (i == 4), (i == 4),
                         2'b10, 5, (i == 4));
        expect_none("t3 extra");

        // T4: nullified TLP followed by a clean DLLP
        send(c_TYPE_TLP_START, 8'h00);
        send(c_TYPE_DATA, 8'hAA);
        send(c_TYPE_DATA, 8'hBB);
        send(c_TYPE_TLP_EDB, 8'h00);
        send(c_TYPE_DLLP_START, 8'h00);
        for (int i = 0; i < 6; i++) send(c_TYPE_DATA, 8'hC0 + 8'(i));
        send(c_TYPE_DLLP_END, 8'h00);
        idle(6);
        expect_entry("t4 aa", 8'hAA, 1, 0, 0, 2'b01, 0, 0);
        expect_entry("t4 bb", 8'hBB, 0, 1, 1, 2'b01, 0, 0);
        for (int i = 0; i < 6; i++)
            expect_entry($sformatf("t4 d%0d", i), 8'hC0 + 8'(i), (i == 0), (i == 5), 0,
                         2'b10, 6, (i == 5));
        expect_none("t4 extra");

        // T5: stray END in IDLE, then an empty TLP
        fe0 = fe_cnt;
        send(c_TYPE_TLP_END, 8'h00);
        idle(3);
        check_eq("t5 stray fe", fe_cnt - fe0, 1);
        fe0 = fe_cnt;
        send(c_TYPE_TLP_START, 8'h00);
        send(c_TYPE_TLP_END, 8'h00);
        idle(3);
        check_eq("t5 empty fe", fe_cnt - fe0, 1);
        expect_none("t5 entries");

        // T6: start inside a packet closes it with err and opens a new one
        fe0 = fe_cnt;
        send(c_TYPE_TLP_START, 8'h00);
        send(c_TYPE_DATA, 8'h01);
        send(c_TYPE_DATA, 8'h02);
        send(c_TYPE_TLP_START, 8'h00);
        send(c_TYPE_DATA, 8'h03);
        send(c_TYPE_TLP_END, 8'h00);
        idle(6);
        expect_entry("t6 01", 8'h01, 1, 0, 0, 2'b01, 0, 0);
        expect_entry("t6 02", 8'h02, 0, 1, 1, 2'b01, 0, 0);
        expect_entry("t6 03", 8'h03, 1, 1, 0, 2'b01, 1, 1);
        expect_none("t6 extra");
        check_eq("t6 fe", fe_cnt - fe0, 1);

        // T7: overflow with a stalled consumer, terminator after drain, then recovery
        out_ready = 1'b0;
        send(c_TYPE_TLP_START, 8'h00);
        for (int i = 1; i <= 20; i++) send(c_TYPE_DATA, 8'h40 + 8'(i));
        send(c_TYPE_TLP_END, 8'h00);
        idle(5);
        check_eq("t7 overflow", overflow, 1);
        check_eq("t7 valid", out_valid, 1);
        check_eq("t7 head", out_data, 8'h41);
        check_eq("t7 no pops", r_q.size(), 0);
        out_ready = 1'b1;
        idle(25);
        for (int i = 0; i < 16; i++)
            expect_entry($sformatf("t7 b%0d", i), 8'h41 + 8'(i), (i == 0), 0, 0, 2'b01, 0, 0);
        expect_entry("t7 term", 8'h00, 0, 1, 1, 2'b01, 0, 0);
        expect_none("t7 extra");
        send(c_TYPE_TLP_START, 8'h00);
        send(c_TYPE_DATA, 8'h5A);
        send(c_TYPE_TLP_END, 8'h00);
        idle(6);
        expect_entry("t7 recov", 8'h5A, 1, 1, 0, 2'b01, 1, 1);
        expect_none("t7 recov extra");
        check_eq("t7 sticky", overflow, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
